// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer
// Stereo I2S transmitter. Derives BCLK and LRCK from clkin and sends one left/right
// pair per frame, MSB first, with the standard one-BCLK data delay. Upstream data
// enters through a single-entry valid/ready holding register.
//
// Optional build macro: I2S_TX_HOLD_LAST_EN
//   defined     - on underrun the previous frame is replayed
//   not defined - on underrun the frame is zero-filled (digital silence)
module i2s_tx_serializer #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              i2s_bclk,
  output logic              i2s_lrck,
  output logic              i2s_sdata,
  output logic              frame_start,
  output logic              underrun
);

  localparam int unsigned FrameW = 2 * SLOT_W;
  localparam int unsigned DcntW  = $clog2(BCLK_DIV);
  localparam int unsigned BcntW  = $clog2(FrameW);

  localparam logic [DcntW-1:0] DcntLast  = DcntW'(BCLK_DIV - 1);
  localparam logic [DcntW-1:0] DcntHalf  = DcntW'(BCLK_DIV / 2);
  localparam logic [DcntW-1:0] DcntOne   = DcntW'(1);
  localparam logic [BcntW-1:0] BcntLast  = BcntW'(FrameW - 1);
  localparam logic [BcntW-1:0] BcntOne   = BcntW'(1);
  localparam logic [BcntW-1:0] BcntRight = BcntW'(SLOT_W);

  // Divider / bit counter state
  logic [DcntW-1:0]  r_dcnt;
  logic [BcntW-1:0]  r_bcnt;
  logic              r_bclk;
  logic              r_lrck;
  logic              r_sdata;
  // Remaining bits of the frame being sent, next bit at the top
  logic [FrameW-1:0] r_shift;

  // Holding register
  logic              r_hold_full;
  logic [DATA_W-1:0] r_hold_left;
  logic [DATA_W-1:0] r_hold_right;

  // Status pulses
  logic              r_frame_start;
  logic              r_underrun;

`ifdef I2S_TX_HOLD_LAST_EN
  // Last loaded frame, replayed when the holding register is empty
  logic [FrameW-1:0] r_frame;
`endif

  logic              w_fe;
  logic [DcntW-1:0]  w_dcnt_nxt;
  logic [BcntW-1:0]  w_bcnt_nxt;
  logic              w_load;
  logic              w_accept;
  logic [SLOT_W-1:0] w_left_slot;
  logic [SLOT_W-1:0] w_right_slot;
  logic [FrameW-1:0] w_fill;
  logic [FrameW-1:0] w_frame_nxt;

  // Falling-edge event, counter next values, load and accept strobes
  always_comb begin
    w_fe       = (r_dcnt == DcntLast);
    w_dcnt_nxt = w_fe ? '0 : (r_dcnt + DcntOne);
    w_bcnt_nxt = r_bcnt;
    if (w_fe) begin
      w_bcnt_nxt = (r_bcnt == BcntLast) ? '0 : (r_bcnt + BcntOne);
    end
    // A frame is loaded on the falling edge that enters bcnt = 1
    w_load   = w_fe && (w_bcnt_nxt == BcntOne);
    w_accept = s_valid && !r_hold_full;
  end

  // Assemble the next frame word: samples left-justified in their slots
  always_comb begin
    w_left_slot                      = '0;
    w_left_slot[SLOT_W-1 -: DATA_W]  = r_hold_left;
    w_right_slot                     = '0;
    w_right_slot[SLOT_W-1 -: DATA_W] = r_hold_right;
`ifdef I2S_TX_HOLD_LAST_EN
    w_fill = r_frame;
`else
    w_fill = '0;
`endif
    w_frame_nxt = r_hold_full ? {w_left_slot, w_right_slot} : w_fill;
  end

  // Clock divider; BCLK is low for the first half of each period
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_dcnt <= '0;
      r_bclk <= 1'b0;
    end else begin
      r_dcnt <= w_dcnt_nxt;
      r_bclk <= (w_dcnt_nxt >= DcntHalf);
    end
  end

  // Bit counter, word select and serial data, all moving with BCLK falling edges
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_bcnt  <= '0;
      r_lrck  <= 1'b0;
      r_sdata <= 1'b0;
      r_shift <= '0;
    end else if (w_fe) begin
      r_bcnt <= w_bcnt_nxt;
      r_lrck <= (w_bcnt_nxt >= BcntRight);
      if (w_load) begin
        // MSB of the new frame goes out on the load edge itself
        r_sdata <= w_frame_nxt[FrameW-1];
        r_shift <= {w_frame_nxt[FrameW-2:0], 1'b0};
      end else begin
        // The last shift lands the previous frame's LSB on bcnt = 0
        r_sdata <= r_shift[FrameW-1];
        r_shift <= {r_shift[FrameW-2:0], 1'b0};
      end
    end
  end

`ifdef I2S_TX_HOLD_LAST_EN
  // Remember each loaded frame for replay on underrun
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_frame <= '0;
    end else if (w_load) begin
      r_frame <= w_frame_nxt;
    end
  end
`endif

  // Holding register; accept needs it empty, so accept and load never collide
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_hold_full  <= 1'b0;
      r_hold_left  <= '0;
      r_hold_right <= '0;
    end else if (w_accept) begin
      r_hold_full  <= 1'b1;
      r_hold_left  <= s_left;
      r_hold_right <= s_right;
    end else if (w_load) begin
      r_hold_full  <= 1'b0;
    end
  end

  // One-cycle frame_start / underrun pulses on each load
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= w_load;
      r_underrun    <= w_load && !r_hold_full;
    end
  end

  assign s_ready     = ~r_hold_full;
  assign i2s_bclk    = r_bclk;
  assign i2s_lrck    = r_lrck;
  assign i2s_sdata   = r_sdata;
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: scoreboard of frame words pushed on accept and
// popped when a frame is observed on the serial outputs.
module tb_i2s_tx_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_left;
  logic [23:0] s_right;
  logic        bclk;
  logic        lrck;
  logic        sdata;
  logic        fs;
  logic        ur;

  logic        fw_valid;
  logic        fw_ready;
  logic [31:0] fw_left;
  logic [31:0] fw_right;
  logic        fw_bclk;
  logic        fw_lrck;
  logic        fw_sdata;
  logic        fw_fs;
  logic        fw_ur;

  int n_chk = 0;
  int n_err = 0;
  int cyc_abs = 0;
  int base = 0;

  logic [63:0] sb_q[$];
  logic [63:0] last_frame = '0;

  // lrck as seen at the 64 BCLK rising edges of a frame, first bit at the top
  localparam logic [63:0] ExpLr = 64'h0000_0001_FFFF_FFFE;

  i2s_tx_serializer u_dut (
    .clkin      (clk),
    .reset      (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_left     (s_left),
    .s_right    (s_right),
    .i2s_bclk   (bclk),
    .i2s_lrck   (lrck),
    .i2s_sdata  (sdata),
    .frame_start(fs),
    .underrun   (ur)
  );

  i2s_tx_serializer #(
    .DATA_W  (32),
    .SLOT_W  (32),
    .BCLK_DIV(4)
  ) u_dut_fw (
    .clkin      (clk),
    .reset      (rst),
    .s_valid    (fw_valid),
    .s_ready    (fw_ready),
    .s_left     (fw_left),
    .s_right    (fw_right),
    .i2s_bclk   (fw_bclk),
    .i2s_lrck   (fw_lrck),
    .i2s_sdata  (fw_sdata),
    .frame_start(fw_fs),
    .underrun   (fw_ur)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    base = cyc_abs;
    sb_q.delete();
    last_frame = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    fw_valid = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  // Advance to #1 after clkin edge n (counted from reset release)
  task automatic wait_until(input int n);
    while (cyc_abs - base < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a pair until accepted; push its frame word to the scoreboard
  task automatic send_pair(input logic [23:0] l, input logic [23:0] r, input int budget,
                           output int acc);
    logic rdy;
    s_left = l;
    s_right = r;
    s_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < budget; i++) begin
      rdy = s_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc = cyc_abs - base;
        sb_q.push_back({l, 8'h00, r, 8'h00});
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  // Expected next frame: popped pair, or the underrun fill when nothing is queued
  task automatic sb_next(output logic [63:0] exp, output logic exp_ur);
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      exp_ur = 1'b0;
    end else begin
      exp_ur = 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
      exp = last_frame;
`else
      exp = '0;
`endif
    end
    last_frame = exp;
  endtask

  // Collect sdata/lrck at the 64 BCLK rising edges following a frame load
  task automatic capture_frame(input bit wait_fs, output logic [63:0] bits,
                               output logic [63:0] lrs, output logic und, output bit ok);
    logic prev;
    int n;
    bits = '0;
    lrs = '0;
    und = 1'b0;
    ok = 1'b0;
    if (wait_fs) begin
      for (int i = 0; i < 600 && !ok; i++) begin
        @(negedge clk);
        if (fs === 1'b1) begin
          ok = 1'b1;
          und = ur;
        end
      end
    end else begin
      ok = 1'b1;
      und = ur;
    end
    if (ok) begin
      prev = bclk;
      n = 0;
      for (int i = 0; i < 400 && n < 64; i++) begin
        @(negedge clk);
        if (bclk === 1'b1 && prev === 1'b0) begin
          bits[63-n] = sdata;
          lrs[63-n] = lrck;
          n++;
        end
        prev = bclk;
      end
      ok = (n == 64);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    s_left = '0;
    s_right = '0;
    fw_valid = 1'b0;
    fw_left = '0;
    fw_right = '0;
    #1;
    n_chk++;
    if ({bclk, lrck, sdata, s_ready, fs, ur} !== 6'b000100) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 000100", {bclk, lrck, sdata, s_ready, fs, ur});
    end
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({bclk, lrck, sdata, s_ready, fs, ur} !== 6'b000100) begin
      n_err++;
      $display("FAIL reset_held: got %b want 000100", {bclk, lrck, sdata, s_ready, fs, ur});
    end
    n_chk++;
    if ({fw_bclk, fw_lrck, fw_sdata, fw_ready, fw_fs, fw_ur} !== 6'b000100) begin
      n_err++;
      $display("FAIL reset_fw_outputs: got %b want 000100",
               {fw_bclk, fw_lrck, fw_sdata, fw_ready, fw_fs, fw_ur});
    end
  endtask

  task automatic test_single_pair();
    int acc;
    logic [63:0] bits, lrs, exp;
    logic und, exp_ur;
    bit ok;
    do_reset();
    send_pair(24'hABCDEF, 24'h123456, 8, acc);
    n_chk++;
    if (acc !== 1) begin
      n_err++;
      $display("FAIL single_accept_cycle: got %0d want 1", acc);
    end
    n_chk++;
    if (s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL single_ready_low: got %b want 0", s_ready);
    end
    wait_until(3);
    n_chk++;
    if (fs !== 1'b0) begin
      n_err++;
      $display("FAIL single_no_early_load: frame_start got %b want 0", fs);
    end
    wait_until(4);
    n_chk++;
    if ({fs, ur, s_ready} !== 3'b101) begin
      n_err++;
      $display("FAIL single_load_cycle4: fs/ur/ready got %b want 101", {fs, ur, s_ready});
    end
    capture_frame(1'b0, bits, lrs, und, ok);
    sb_next(exp, exp_ur);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL single_capture: got incomplete frame want 64 bits");
    end
    n_chk++;
    if (bits !== exp) begin
      n_err++;
      $display("FAIL single_frame: got %h want %h", bits, exp);
    end
    n_chk++;
    if (lrs !== ExpLr) begin
      n_err++;
      $display("FAIL single_lrck: got %h want %h", lrs, ExpLr);
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2;
    logic [63:0] b1, l1, b2, l2, exp;
    logic u1, u2, exp_ur;
    bit ok1, ok2;
    do_reset();
    fork
      begin
        send_pair(24'h800001, 24'h7FFFFE, 8, acc1);
        send_pair(24'h0F0F0F, 24'hF0F0F0, 12, acc2);
      end
      begin
        capture_frame(1'b1, b1, l1, u1, ok1);
        capture_frame(1'b1, b2, l2, u2, ok2);
      end
    join
    n_chk++;
    if (acc1 !== 1 || acc2 !== 5) begin
      n_err++;
      $display("FAIL b2b_accept_cycles: got %0d,%0d want 1,5", acc1, acc2);
    end
    n_chk++;
    if (!(ok1 && ok2)) begin
      n_err++;
      $display("FAIL b2b_capture: got ok=%0d,%0d want 1,1", ok1, ok2);
    end
    sb_next(exp, exp_ur);
    n_chk++;
    if (b1 !== exp || u1 !== exp_ur) begin
      n_err++;
      $display("FAIL b2b_frame1: got %h ur=%b want %h ur=%b", b1, u1, exp, exp_ur);
    end
    sb_next(exp, exp_ur);
    n_chk++;
    if (b2 !== exp || u2 !== exp_ur) begin
      n_err++;
      $display("FAIL b2b_frame2: got %h ur=%b want %h ur=%b", b2, u2, exp, exp_ur);
    end
    n_chk++;
    if (l1 !== ExpLr || l2 !== ExpLr) begin
      n_err++;
      $display("FAIL b2b_lrck: got %h,%h want %h", l1, l2, ExpLr);
    end
  endtask

  task automatic test_underrun();
    int acc;
    logic [63:0] b1, l1, b2, l2, exp;
    logic u1, u2, exp_ur;
    bit ok1, ok2;
    do_reset();
    send_pair(24'hC3A5E1, 24'h5A3C96, 8, acc);
    capture_frame(1'b1, b1, l1, u1, ok1);
    capture_frame(1'b1, b2, l2, u2, ok2);
    n_chk++;
    if (!(ok1 && ok2)) begin
      n_err++;
      $display("FAIL underrun_capture: got ok=%0d,%0d want 1,1", ok1, ok2);
    end
    sb_next(exp, exp_ur);
    n_chk++;
    if (b1 !== exp || u1 !== exp_ur) begin
      n_err++;
      $display("FAIL underrun_frame1: got %h ur=%b want %h ur=%b", b1, u1, exp, exp_ur);
    end
    sb_next(exp, exp_ur);
    n_chk++;
    if (u2 !== exp_ur) begin
      n_err++;
      $display("FAIL underrun_pulse: got %b want %b", u2, exp_ur);
    end
    n_chk++;
    if (b2 !== exp) begin
      n_err++;
      $display("FAIL underrun_fill: got %h want %h", b2, exp);
    end
    n_chk++;
    if (l2 !== ExpLr) begin
      n_err++;
      $display("FAIL underrun_lrck: got %h want %h", l2, ExpLr);
    end
  endtask

  task automatic test_shape();
    int acc;
    logic prev_b, prev_l, prev_d, fall;
    int run, bad_b, bad_l, bad_d, last_rise, period;
    bit first;
    do_reset();
    send_pair(24'hA5F00F, 24'h3C00C3, 8, acc);
    prev_b = bclk;
    prev_l = lrck;
    prev_d = sdata;
    run = 0;
    first = 1'b1;
    bad_b = 0;
    bad_l = 0;
    bad_d = 0;
    last_rise = -1;
    period = -1;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      fall = (prev_b === 1'b1 && bclk === 1'b0);
      if (bclk !== prev_b) begin
        if (!first && run != 2) bad_b++;
        first = 1'b0;
        run = 1;
      end else begin
        run++;
      end
      if (lrck !== prev_l) begin
        if (!fall) bad_l++;
        if (lrck === 1'b1) begin
          if (last_rise >= 0) period = i - last_rise;
          last_rise = i;
        end
      end
      if (sdata !== prev_d && !fall) bad_d++;
      prev_b = bclk;
      prev_l = lrck;
      prev_d = sdata;
    end
    n_chk++;
    if (bad_b !== 0) begin
      n_err++;
      $display("FAIL shape_bclk_duty: got %0d bad half-periods want 0", bad_b);
    end
    n_chk++;
    if (bad_l !== 0) begin
      n_err++;
      $display("FAIL shape_lrck_edge: got %0d off-edge changes want 0", bad_l);
    end
    n_chk++;
    if (bad_d !== 0) begin
      n_err++;
      $display("FAIL shape_sdata_edge: got %0d off-edge changes want 0", bad_d);
    end
    n_chk++;
    if (period !== 256) begin
      n_err++;
      $display("FAIL shape_lrck_period: got %0d want 256", period);
    end
  endtask

  task automatic test_mid_reset();
    int acc1, acc2;
    logic [63:0] bits, lrs, exp;
    logic und, exp_ur;
    bit ok;
    do_reset();
    send_pair(24'hFFFFFF, 24'h000000, 8, acc1);
    send_pair(24'h123123, 24'h456456, 12, acc2);
    wait_until(82);
    n_chk++;
    if ({bclk, sdata, s_ready} !== 3'b110) begin
      n_err++;
      $display("FAIL midreset_pre: bclk/sdata/ready got %b want 110", {bclk, sdata, s_ready});
    end
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({bclk, lrck, sdata, s_ready, fs, ur} !== 6'b000100) begin
      n_err++;
      $display("FAIL midreset_async: got %b want 000100", {bclk, lrck, sdata, s_ready, fs, ur});
    end
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({bclk, lrck, sdata, s_ready, fs, ur} !== 6'b000100) begin
      n_err++;
      $display("FAIL midreset_held: got %b want 000100", {bclk, lrck, sdata, s_ready, fs, ur});
    end
    release_reset();
    capture_frame(1'b1, bits, lrs, und, ok);
    sb_next(exp, exp_ur);
    n_chk++;
    if (!ok || und !== exp_ur) begin
      n_err++;
      $display("FAIL midreset_underrun: got ok=%0d ur=%b want ok=1 ur=%b", ok, und, exp_ur);
    end
    n_chk++;
    if (bits !== exp) begin
      n_err++;
      $display("FAIL midreset_frame: got %h want %h", bits, exp);
    end
  endtask

  task automatic test_full_width();
    do_reset();
    fw_left = 32'h8000_0000;
    fw_right = 32'h0000_0001;
    fw_valid = 1'b1;
    @(posedge clk);
    #1;
    fw_valid = 1'b0;
    n_chk++;
    if (fw_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fw_accept: ready got %b want 0", fw_ready);
    end
    wait_until(4);
    n_chk++;
    if ({fw_fs, fw_sdata, fw_lrck} !== 3'b110) begin
      n_err++;
      $display("FAIL fw_left_msb: fs/sdata/lrck got %b want 110", {fw_fs, fw_sdata, fw_lrck});
    end
    wait_until(252);
    n_chk++;
    if ({fw_sdata, fw_lrck} !== 2'b01) begin
      n_err++;
      $display("FAIL fw_bcnt63: sdata/lrck got %b want 01", {fw_sdata, fw_lrck});
    end
    wait_until(256);
    n_chk++;
    if ({fw_sdata, fw_lrck} !== 2'b10) begin
      n_err++;
      $display("FAIL fw_right_lsb: sdata/lrck got %b want 10", {fw_sdata, fw_lrck});
    end
    wait_until(260);
    n_chk++;
    if ({fw_fs, fw_ur} !== 2'b11) begin
      n_err++;
      $display("FAIL fw_second_load: fs/ur got %b want 11", {fw_fs, fw_ur});
    end
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_back_to_back();
    test_underrun();
    test_shape();
    test_mid_reset();
    test_full_width();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
